// File: rtl/cp0_intc_if.sv
// Pipeline-side bus of the CP0 interrupt controller.
// The pipeline is the master, the CP0 block is the slave.
interface cp0_intc_if #(
  parameter int NUM_IRQ = 6
);
  logic [1:0]         oper;
  logic [4:0]         addr_r;
  logic [31:0]        data_r;
  logic [4:0]         addr_w;
  logic [31:0]        data_w;
  logic               ir_en;
  logic [NUM_IRQ-1:0] ir_in;
  logic [31:0]        ret_addr;
  logic               jump_en;
  logic [31:0]        jump_addr;
  logic               irq_pending;
  logic               irout;

  modport master (
    output oper, addr_r, addr_w, data_w,
    output ir_en, ir_in, ret_addr,
    input  data_r, jump_en, jump_addr,
    input  irq_pending, irout
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w,
    input  ir_en, ir_in, ret_addr,
    output data_r, jump_en, jump_addr,
    output irq_pending, irout
  );
endinterface

// File: rtl/cp0_intc.sv
// CP0 with multi-line vectored interrupt controller and compare timer.
// Sources 0..NUM_IRQ-1 are external, source NUM_IRQ is the timer.
module cp0_intc #(
  parameter int NUM_IRQ     = 6,
  parameter int VEC_SPACING = 32,
  parameter int TCR_W       = 32
) (
  input  logic      clk,
  input  logic      rst,
  cp0_intc_if.slave bus
);
  localparam int NI = NUM_IRQ + 1;
  localparam int VSH = $clog2(VEC_SPACING);
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_ERET  = 2'd2;

  logic              ie_q, ie_d;
  logic              exl_q, exl_d;
  logic [NI-1:0]     im_q, im_d;
  logic [NI-1:0]     ip_q, ip_d;
  logic [4:0]        exc_q, exc_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       ehbr_q, ehbr_d;
  logic [TCR_W-1:0]  tcr_q, tcr_d;
  logic [TCR_W-1:0]  tcmp_q, tcmp_d;
  logic [31:0]       data_r_q, data_r_d;
  logic [NUM_IRQ-1:0] irs_q;

  logic [NI-1:0] pend;
  logic [NI-1:0] set_m;
  logic [NI-1:0] clr_m;
  logic [4:0]    idx;
  logic          take, eret, wr, t_hit;
  logic [31:0]   status_w, cause_w, rd_val;

  assign pend  = ip_q & im_q;
  assign take  = bus.ir_en & ie_q & ~exl_q & (|pend);
  assign eret  = (bus.oper == OP_ERET) & ~take;
  assign wr    = (bus.oper == OP_STORE) & ~take;
  assign t_hit = (tcr_q == tcmp_q) && (tcmp_q != '0);

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    idx = '0;
    for (int i = NI - 1; i >= 0; i--)
      if (pend[i]) idx = 5'(i);
  end

  assign status_w = (32'(im_q) << 8) | {30'b0, exl_q, ie_q};
  assign cause_w  = (32'(ip_q) << 8) | 32'(exc_q);

  always_comb begin
    rd_val = '0;
    case (bus.addr_r)
      5'd0:    rd_val = status_w;
      5'd1:    rd_val = cause_w;
      5'd2:    rd_val = epc_q;
      5'd3:    rd_val = ehbr_q;
      5'd4:    rd_val = 32'(tcr_q);
      5'd5:    rd_val = 32'(tcmp_q);
      default: rd_val = '0;
    endcase
  end

  assign data_r_d = (bus.oper == OP_STORE) ? data_r_q : rd_val;

  assign set_m = {t_hit, bus.ir_in & ~irs_q};

  always_comb begin
    clr_m = '0;
    if (wr && bus.addr_w == 5'd1) clr_m = bus.data_w[8 +: NI];
    if (wr && bus.addr_w == 5'd5) clr_m[NI-1] = 1'b1;
  end

  // Set beats a same-cycle write-1-to-clear.
  assign ip_d = (ip_q & ~clr_m) | set_m;

  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    im_d   = im_q;
    exc_d  = exc_q;
    epc_d  = epc_q;
    ehbr_d = ehbr_q;
    tcr_d  = tcr_q + TCR_W'(1);
    tcmp_d = tcmp_q;
    unique case (1'b1)
      take: begin
        exl_d = 1'b1;
        epc_d = bus.ret_addr;
        exc_d = idx;
      end
      eret:    exl_d = 1'b0;
      default: ;
    endcase
    if (wr) begin
      case (bus.addr_w)
        5'd0: begin
          ie_d  = bus.data_w[0];
          exl_d = bus.data_w[1];
          im_d  = bus.data_w[8 +: NI];
        end
        5'd2:    epc_d  = bus.data_w;
        5'd3:    ehbr_d = bus.data_w;
        5'd4:    tcr_d  = bus.data_w[TCR_W-1:0];
        5'd5:    tcmp_d = bus.data_w[TCR_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q     <= 1'b1;
      exl_q    <= 1'b0;
      im_q     <= '1;
      ip_q     <= '0;
      exc_q    <= '0;
      epc_q    <= '0;
      ehbr_q   <= '0;
      tcr_q    <= '0;
      tcmp_q   <= '0;
      data_r_q <= '0;
      irs_q    <= '0;
    end else begin
      ie_q     <= ie_d;
      exl_q    <= exl_d;
      im_q     <= im_d;
      ip_q     <= ip_d;
      exc_q    <= exc_d;
      epc_q    <= epc_d;
      ehbr_q   <= ehbr_d;
      tcr_q    <= tcr_d;
      tcmp_q   <= tcmp_d;
      data_r_q <= data_r_d;
      irs_q    <= bus.ir_in;
    end
  end

  assign bus.data_r      = data_r_q;
  assign bus.jump_en     = take | eret;
  assign bus.jump_addr   = take ? ehbr_q + (32'(idx) << VSH) : epc_q;
  assign bus.irq_pending = |pend;
  assign bus.irout       = ie_q & ~exl_q;
endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
Parametrised CP0 coprocessor with a multi-line vectored interrupt controller and a compare timer.
- Reads CP0 registers in the ID stage and writes them in the EXE stage.
- Checks interrupts in the MEM stage and drives a forced jump to a per-source vector or, on ERET, to EPC.
- Generalises the single-line CP0: NUM_IRQ masked, edge-latched sources, fixed priority, cause recording and a timer compare interrupt.

Parameters:
NUM_IRQ, 6, number of external interrupt lines (1..16); timer source is internal index NUM_IRQ
VEC_SPACING, 32, byte distance between consecutive vectors (power of two)
TCR_W, 32, timer counter width (<=32; zero-extended on read)

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
oper  in  2  0 = NONE/read, 1 = STORE, 2 = ERET, 3 = reserved (treated as NONE)
addr_r  in  5  read address
data_r  out  32  registered read data
addr_w  in  5  write address
data_w  in  32  write data
ir_en  in  1  pipeline permits interrupt take this cycle
ir_in  in  NUM_IRQ  external interrupt lines, synchronous to clk
ret_addr  in  32  address saved to EPC on take
jump_en  out  1  combinational force-jump
jump_addr  out  32  combinational jump target
irq_pending  out  1  any enabled source pending (pending & IM non-zero)
irout  out  1  interrupts accepted (STATUS.IE & !STATUS.EXL)

Behaviour:
Register map (32-bit); unmapped addresses read 0, writes ignored:
- 0 STATUS: bit0 IE, bit1 EXL, bits[8+NUM_IRQ:8] IM (one bit per source incl. timer).
- 1 CAUSE: bits[8+NUM_IRQ:8] IP, bits[4:0] EXCCODE = index of last taken source.
- 2 EPC. 3 EHBR. 4 TCR. 5 TCMP.

Reset (rst=1 at posedge):
- STATUS: IE=1, EXL=0, IM all ones.
- All other registers 0; ir_in sample flops 0; data_r 0.
- rst overrides every other event that cycle.

Read path:
- When oper != STORE: data_r <= reg[addr_r] at posedge (1-cycle latency).
- Otherwise data_r holds.

Write path:
- oper=STORE and no take: reg[addr_w] <= data_w at posedge.
- CAUSE write: IP bits are write-1-to-clear; EXCCODE is read-only.
- TCMP write also clears timer IP.
- TCR write loads data_w with no increment that cycle; otherwise TCR increments every cycle and wraps 2^TCR_W-1 -> 0.

Pending sources:
- IP[i] sets on a rising edge of ir_in[i] (previous sample 0, current 1).
- Timer IP sets the cycle TCR == TCMP (pre-increment value) and TCMP != 0.
- A set and a W1C clear on the same bit in the same cycle: set wins.

Take:
- Condition: take = ir_en & IE & !EXL & |(IP & IM).
- Selected source: lowest index with IP & IM set (index 0 = highest priority; timer lowest).
- Combinationally in the same cycle: jump_en=1, jump_addr = EHBR + idx*VEC_SPACING.
- At posedge: EPC <= ret_addr, EXL <= 1, EXCCODE <= idx.
- IP is not cleared by the take; the handler clears it via W1C.
- A STORE in a take cycle is dropped.

ERET:
- oper=ERET and no take: jump_en=1, jump_addr=EPC (value before any same-cycle write); EXL <= 0 at posedge.
- ERET coinciding with a take: take wins and ERET is ignored.

Idle outputs:
- When neither take nor ERET: jump_en=0 and jump_addr=EPC.
- Re-entry is blocked while EXL=1 regardless of ir_in.

Test Plan:
1. Reset, EHBR=0x100, pulse ir_in[2] with ir_en=1, ret_addr=0x40 -> same cycle jump_en=1, jump_addr=0x140; next cycle EPC=0x40, EXL=1, EXCCODE=2.
2. ir_in[1] and ir_in[3] rise together -> vector 0x120, EXCCODE=1; after ERET plus W1C of bit1 -> second take to 0x160.
3. While EXL=1, pulse ir_in[0] -> no jump and IP[0]=1 latched; then ERET with EPC=0x40 -> jump_addr=0x40, EXL=0; next eligible cycle takes vector 0x100.
4. IM bit4=0, pulse ir_in[4] -> irq_pending=0 and no take; set IM bit4 -> take to 0x180.
5. TCMP=10, TCR=0, IM timer set (NUM_IRQ=6) -> timer IP sets when TCR==10; take to EHBR+6*32=0x1C0; writing TCMP clears IP; TCR=0xFFFFFFFF wraps to 0.
6. Take and STORE to EHBR in the same cycle -> EHBR unchanged; assert rst mid-handler -> EXL=0, IE=1, all IP=0, data_r=0 next cycle.
